// File: rtl/inst_port_arbiter_pkg.sv
// Shared types for the instruction-port arbiter.
//   owner_e      : which requester owns an outstanding request (fetch or cache-op)
//   fifo_entry_t : one outstanding-request record {owner, discard}
//   arb_state_e  : grant FSM state
//   hold_t       : request fields captured at grant time and replayed while locked
package inst_port_arbiter_pkg;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_A = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   discard;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_F = 2'd1,
    LOCK_A = 2'd2
  } arb_state_e;

  typedef struct packed {
    owner_e      owner;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        cached;
  } hold_t;

endpackage

// File: rtl/inst_owner_fifo.sv
// Owner FIFO: remembers who issued each accepted-but-unanswered icache request
// so that in-order responses can be routed back to the right requester.
//   clk, resetn   : clock, asynchronous active-low reset
//   push_i        : append push_entry_i
//   push_entry_i  : {owner, discard} of the request being accepted
//   pop_i         : remove head entry (ignored when empty)
//   flush_f_i     : mark every stored fetch-owned entry as discard
//   head_o        : current head entry
//   count_o       : number of stored entries
//   empty_o/full_o: occupancy flags
module inst_owner_fifo
  import inst_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  fifo_entry_t              push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_f_i,
  output fifo_entry_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fifo_entry_t     mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q;
  logic [PW-1:0]   rdPtr_q;
  logic [CW-1:0]   count_q;
  logic            doPop;

  assign doPop   = pop_i & (count_q != '0);
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // Storage, pointers and occupancy. The flush marking is applied before the
  // push write, so an entry pushed in the flush cycle keeps whatever discard
  // value the caller computed for it. Pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (flush_f_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem_q[i].owner == OWN_F) begin
            mem_q[i].discard <= 1'b1;
          end
        end
      end
      if (push_i) begin
        mem_q[wrPtr_q] <= push_entry_i;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({push_i, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_port_arbiter.sv
// Instruction-port arbiter: shares the single icache request port between the
// fetch unit (f_*) and the cache-op unit (a_*). A wins in IDLE; a grant not
// accepted the same cycle is locked and replayed from a hold register. Fetch
// responses in flight across a pipeline redirect (flush) are dropped.
//   clk, resetn                      : clock, asynchronous active-low reset
//   f_req/addr/size/cached -> f_addr_ok, f_data_ok, f_rdata : fetch side
//   a_req/addr/size/cached -> a_addr_ok, a_data_ok, a_rdata : cache-op side
//   flush                            : pipeline redirect
//   m_req/addr/size/cached <- m_addr_ok, m_data_ok, m_rdata : icache side
//   busy                             : requests outstanding or grant locked
//   proto_err                        : sticky, response seen with nothing outstanding
module inst_port_arbiter
  import inst_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int DW        = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  input  logic [1:0]    f_size,
  input  logic          f_cached,
  output logic          f_addr_ok,
  output logic          f_data_ok,
  output logic [DW-1:0] f_rdata,
  input  logic          a_req,
  input  logic [31:0]   a_addr,
  input  logic [1:0]    a_size,
  input  logic          a_cached,
  output logic          a_addr_ok,
  output logic          a_data_ok,
  output logic [DW-1:0] a_rdata,
  input  logic          flush,
  output logic          m_req,
  output logic [31:0]   m_addr,
  output logic [1:0]    m_size,
  output logic          m_cached,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          proto_err
);

  localparam int CW = $clog2(MAX_OUTST) + 1;

  arb_state_e  state_q, state_d;
  hold_t       hold_q, hold_d;
  logic        zombie_q, zombie_d;
  logic        zombieNow;
  logic        protoErr_q;
  logic        push;
  fifo_entry_t pushEntry;
  fifo_entry_t head;
  logic [CW-1:0] count;
  logic        fifoEmpty;
  logic        fifoFull;
  logic        pop;

  inst_owner_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_owner_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push),
    .push_entry_i(pushEntry),
    .pop_i       (m_data_ok),
    .flush_f_i   (flush),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (fifoEmpty),
    .full_o      (fifoFull)
  );

  // Grant FSM and request-side outputs. Everything is gated by resetn so the
  // combinational outputs also read 0 while reset is held. Fullness uses the
  // registered count, so a pop in the same cycle cannot reopen the port.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    zombie_d  = zombie_q;
    zombieNow = 1'b0;
    m_req     = 1'b0;
    m_addr    = '0;
    m_size    = '0;
    m_cached  = 1'b0;
    f_addr_ok = 1'b0;
    a_addr_ok = 1'b0;
    push      = 1'b0;
    pushEntry = '0;
    if (resetn) begin
      case (state_q)
        IDLE: begin
          if (!fifoFull && a_req) begin
            m_req    = 1'b1;
            m_addr   = a_addr;
            m_size   = a_size;
            m_cached = a_cached;
            hold_d   = '{owner: OWN_A, addr: a_addr, size: a_size, cached: a_cached};
            if (m_addr_ok) begin
              a_addr_ok = 1'b1;
              push      = 1'b1;
              pushEntry = '{owner: OWN_A, discard: 1'b0};
            end else begin
              state_d = LOCK_A;
            end
          end else if (!fifoFull && f_req && !flush) begin
            m_req    = 1'b1;
            m_addr   = f_addr;
            m_size   = f_size;
            m_cached = f_cached;
            hold_d   = '{owner: OWN_F, addr: f_addr, size: f_size, cached: f_cached};
            zombie_d = 1'b0;
            if (m_addr_ok) begin
              f_addr_ok = 1'b1;
              push      = 1'b1;
              pushEntry = '{owner: OWN_F, discard: 1'b0};
            end else begin
              state_d = LOCK_F;
            end
          end
        end
        LOCK_A: begin
          m_req    = 1'b1;
          m_addr   = hold_q.addr;
          m_size   = hold_q.size;
          m_cached = hold_q.cached;
          if (m_addr_ok) begin
            a_addr_ok = 1'b1;
            push      = 1'b1;
            pushEntry = '{owner: OWN_A, discard: 1'b0};
            state_d   = IDLE;
          end
        end
        LOCK_F: begin
          // Once fetch withdraws or a redirect hits, the handshake is finished
          // on the icache side but its result is thrown away.
          zombieNow = zombie_q | flush | ~f_req;
          m_req     = 1'b1;
          m_addr    = hold_q.addr;
          m_size    = hold_q.size;
          m_cached  = hold_q.cached;
          if (m_addr_ok) begin
            f_addr_ok = ~zombieNow;
            push      = 1'b1;
            pushEntry = '{owner: OWN_F, discard: zombieNow};
            state_d   = IDLE;
            zombie_d  = 1'b0;
          end else begin
            zombie_d  = zombieNow;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, hold register and zombie flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      zombie_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      zombie_q <= zombie_d;
    end
  end

  // Response routing straight from m_data_ok; a fetch response popping in a
  // flush cycle is suppressed just like one already marked discard.
  assign pop       = m_data_ok & ~fifoEmpty;
  assign a_data_ok = pop & (head.owner == OWN_A);
  assign f_data_ok = pop & (head.owner == OWN_F) & ~head.discard & ~flush;
  assign a_rdata   = a_data_ok ? m_rdata : '0;
  assign f_rdata   = f_data_ok ? m_rdata : '0;

  // Sticky protocol error: a response arrived with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      protoErr_q <= 1'b0;
    end else if (m_data_ok && fifoEmpty) begin
      protoErr_q <= 1'b1;
    end
  end

  assign proto_err = protoErr_q;
  assign busy      = (count != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_inst_port_arbiter.sv
// Directed self-checking bench for inst_port_arbiter.
module tb_inst_port_arbiter;

  localparam int DW = 64;

  logic          clk;
  logic          resetn;
  logic          f_req;
  logic [31:0]   f_addr;
  logic [1:0]    f_size;
  logic          f_cached;
  logic          f_addr_ok;
  logic          f_data_ok;
  logic [DW-1:0] f_rdata;
  logic          a_req;
  logic [31:0]   a_addr;
  logic [1:0]    a_size;
  logic          a_cached;
  logic          a_addr_ok;
  logic          a_data_ok;
  logic [DW-1:0] a_rdata;
  logic          flush;
  logic          m_req;
  logic [31:0]   m_addr;
  logic [1:0]    m_size;
  logic          m_cached;
  logic          m_addr_ok;
  logic          m_data_ok;
  logic [DW-1:0] m_rdata;
  logic          busy;
  logic          proto_err;

  int compared;
  int mismatched;

  inst_port_arbiter #(
    .MAX_OUTST(4),
    .DW       (DW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_size   (f_size),
    .f_cached (f_cached),
    .f_addr_ok(f_addr_ok),
    .f_data_ok(f_data_ok),
    .f_rdata  (f_rdata),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_size   (a_size),
    .a_cached (a_cached),
    .a_addr_ok(a_addr_ok),
    .a_data_ok(a_data_ok),
    .a_rdata  (a_rdata),
    .flush    (flush),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_size   (m_size),
    .m_cached (m_cached),
    .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok),
    .m_rdata  (m_rdata),
    .busy     (busy),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then wait to the falling edge for sampling.
  task automatic applyStimulus(input logic fReq, input logic [31:0] fAddr,
                               input logic aReq, input logic [31:0] aAddr,
                               input logic mAddrOk, input logic mDataOk,
                               input logic [63:0] mRdata, input logic fl);
    f_req     = fReq;
    f_addr    = fAddr;
    a_req     = aReq;
    a_addr    = aAddr;
    m_addr_ok = mAddrOk;
    m_data_ok = mDataOk;
    m_rdata   = mRdata;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    f_req = 1'b0; f_addr = '0; a_req = 1'b0; a_addr = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0; flush = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetn     = 1'b0;
    f_size     = 2'd2;
    f_cached   = 1'b1;
    a_size     = 2'd1;
    a_cached   = 1'b0;
    clearInputs();

    // Reset state
    #2;
    checkOutput("rst_mreq", m_req, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_perr", proto_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // 1: back-to-back fetch
    applyStimulus(1'b1, 32'h1FC0_0000, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t1_mreq0", m_req, 1'b1);
    checkOutput("t1_maddr0", m_addr, 32'h1FC0_0000);
    checkOutput("t1_msize0", m_size, 2'd2);
    checkOutput("t1_faok0", f_addr_ok, 1'b1);
    checkOutput("t1_aaok0", a_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h1FC0_0008, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t1_maddr1", m_addr, 32'h1FC0_0008);
    checkOutput("t1_faok1", f_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    checkOutput("t1_fdok0", f_data_ok, 1'b1);
    checkOutput("t1_frd0", f_rdata, 64'hDEAD_BEEF_0000_0001);
    checkOutput("t1_adok0", a_data_ok, 1'b0);
    checkOutput("t1_ard0", a_rdata, 64'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0002, 1'b0);
    checkOutput("t1_fdok1", f_data_ok, 1'b1);
    checkOutput("t1_frd1", f_rdata, 64'hDEAD_BEEF_0000_0002);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t1_busy", busy, 1'b0);
    nextCycle();

    // 2: contention, A wins and is locked for 3 cycles
    applyStimulus(1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t2_maddr_c0", m_addr, 32'h0000_2000);
    checkOutput("t2_msize_c0", m_size, 2'd1);
    checkOutput("t2_aaok_c0", a_addr_ok, 1'b0);
    checkOutput("t2_faok_c0", f_addr_ok, 1'b0);
    nextCycle();
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 64'h0, 1'b0);
      checkOutput("t2_maddr_lock", m_addr, 32'h0000_2000);
      checkOutput("t2_mreq_lock", m_req, 1'b1);
      checkOutput("t2_busy_lock", busy, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t2_maddr_acc", m_addr, 32'h0000_2000);
    checkOutput("t2_aaok_acc", a_addr_ok, 1'b1);
    checkOutput("t2_faok_acc", f_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t2_maddr_f", m_addr, 32'h0000_1000);
    checkOutput("t2_faok_f", f_addr_ok, 1'b1);
    checkOutput("t2_aaok_f", a_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0A0A_0000_0000_00AA, 1'b0);
    checkOutput("t2_adok", a_data_ok, 1'b1);
    checkOutput("t2_ard", a_rdata, 64'h0A0A_0000_0000_00AA);
    checkOutput("t2_fdok_a", f_data_ok, 1'b0);
    checkOutput("t2_frd_a", f_rdata, 64'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0F0F_0000_0000_00FF, 1'b0);
    checkOutput("t2_fdok", f_data_ok, 1'b1);
    checkOutput("t2_frd", f_rdata, 64'h0F0F_0000_0000_00FF);
    checkOutput("t2_adok_f", a_data_ok, 1'b0);
    nextCycle();

    // 3: flush with 3 fetches outstanding
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0000_0100 + 32'(i * 8), 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("t3_faok", f_addr_ok, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t3_mreq_flush", m_req, 1'b0);
    checkOutput("t3_faok_flush", f_addr_ok, 1'b0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b0);
      checkOutput("t3_fdok_drop", f_data_ok, 1'b0);
      checkOutput("t3_frd_drop", f_rdata, 64'h0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t3_busy_drained", busy, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t3_faok_new", f_addr_ok, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h5555_6666_7777_8888, 1'b0);
    checkOutput("t3_fdok_new", f_data_ok, 1'b1);
    checkOutput("t3_frd_new", f_rdata, 64'h5555_6666_7777_8888);
    nextCycle();

    // 4: zombie fetch
    applyStimulus(1'b1, 32'h0000_0400, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t4_mreq_c0", m_req, 1'b1);
    checkOutput("t4_faok_c0", f_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_mreq_flush", m_req, 1'b1);
    checkOutput("t4_maddr_flush", m_addr, 32'h0000_0400);
    checkOutput("t4_mcached_flush", m_cached, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t4_mreq_wait", m_req, 1'b1);
    checkOutput("t4_maddr_wait", m_addr, 32'h0000_0400);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t4_mreq_acc", m_req, 1'b1);
    checkOutput("t4_faok_acc", f_addr_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    checkOutput("t4_busy_resp", busy, 1'b1);
    checkOutput("t4_fdok_drop", f_data_ok, 1'b0);
    checkOutput("t4_adok_drop", a_data_ok, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t4_busy_end", busy, 1'b0);
    nextCycle();

    // 5: FIFO full blocks the port; a pop reopens it only on the next cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0000_0500 + 32'(i * 8), 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("t5_fill_faok", f_addr_ok, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h0000_0520, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t5_mreq_full", m_req, 1'b0);
    checkOutput("t5_faok_full", f_addr_ok, 1'b0);
    checkOutput("t5_busy_full", busy, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0520, 1'b0, 32'h0, 1'b1, 1'b1, 64'h0000_0000_0000_0500, 1'b0);
    checkOutput("t5_mreq_popcyc", m_req, 1'b0);
    checkOutput("t5_fdok_popcyc", f_data_ok, 1'b1);
    checkOutput("t5_frd_popcyc", f_rdata, 64'h0000_0000_0000_0500);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0520, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t5_mreq_reopen", m_req, 1'b1);
    checkOutput("t5_faok_reopen", f_addr_ok, 1'b1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0000_0000_0000_0508 + 64'(i * 8), 1'b0);
      checkOutput("t5_drain_fdok", f_data_ok, 1'b1);
      checkOutput("t5_drain_frd", f_rdata, 64'h0000_0000_0000_0508 + 64'(i * 8));
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t5_busy_end", busy, 1'b0);
    checkOutput("t5_perr", proto_err, 1'b0);
    nextCycle();

    // 6: async reset with two fetches outstanding
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h0000_0600 + 32'(i * 8), 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
      nextCycle();
    end
    f_req = 1'b1; f_addr = 32'h0000_0610; a_req = 1'b1; a_addr = 32'h0000_2600;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 64'hFFFF_0000_FFFF_0000;
    #1;
    checkOutput("t6_busy_pre", busy, 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("t6_mreq_rst", m_req, 1'b0);
    checkOutput("t6_maddr_rst", m_addr, 32'h0);
    checkOutput("t6_faok_rst", f_addr_ok, 1'b0);
    checkOutput("t6_aaok_rst", a_addr_ok, 1'b0);
    checkOutput("t6_fdok_rst", f_data_ok, 1'b0);
    checkOutput("t6_adok_rst", a_data_ok, 1'b0);
    checkOutput("t6_frd_rst", f_rdata, 64'h0);
    checkOutput("t6_busy_rst", busy, 1'b0);
    checkOutput("t6_perr_rst", proto_err, 1'b0);
    clearInputs();
    nextCycle();
    resetn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    checkOutput("t6_fdok_stray", f_data_ok, 1'b0);
    checkOutput("t6_perr_before", proto_err, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t6_perr_set", proto_err, 1'b1);
    checkOutput("t6_busy_after", busy, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t6_perr_sticky", proto_err, 1'b1);
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
